dmem_req_arbiter: RTL
=====================

// Module: dmem_req_arbiter
// PURPOSE
//  Shares the single data-memory port (req/gnt/rvalid protocol) between two requesters:
//  m0 = core load/store path, m1 = secondary master (debug/DMA).
//  Arbitrates, then drives one bus transaction at a time, aligned and with correct byte enables.
//  Routes the response back to the winner; misaligned accesses never reach the bus.
//  Sits between the core/debug masters and the memory-side port pins.
// PARAMETERS
//  RR_EN   1  1: round-robin between m0/m1; 0: fixed priority, m0 wins
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_ni       in   1   asynchronous active-low reset
//  mN_req_i     in   1   request, N=0,1; held with its attributes stable until mN_gnt_o
//  mN_we_i      in   1   1 = store, 0 = load
//  mN_size_i    in   2   00 byte, 01 half, 10 word, 11 illegal
//  mN_addr_i    in   32  byte address
//  mN_wdata_i   in   32  store data, LSB-justified
//  mN_gnt_o     out  1   one-cycle pulse: request accepted
//  mN_rvalid_o  out  1   one-cycle pulse: response valid
//  mN_rdata_o   out  32  load data, LSB-justified, zero-extended per size; 0 when !rvalid
//  mN_err_o     out  1   qualified by mN_rvalid_o: bus error or misaligned/illegal
//  data_req_o   out  1   bus request
//  data_we_o    out  1   bus write enable
//  data_be_o    out  4   byte enables
//  data_addr_o  out  32  word address, [1:0] = 00
//  data_wdata_o out  32  store data shifted to byte lane
//  data_gnt_i   in   1   bus grant
//  data_rvalid_i in  1   bus response valid
//  data_rdata_i in   32  bus read data
//  data_err_i   in   1   bus error, qualified by data_rvalid_i
// BEHAVIOUR
//  Reset: state IDLE, rr pointer favours m0, latched transaction cleared; all outputs 0.
//  FSM IDLE -> REQ | ERR; REQ -> RESP on data_gnt_i; RESP -> IDLE on data_rvalid_i; ERR -> IDLE.
//  IDLE: if any mN_req_i, pick winner, register its we/size/addr/wdata.
//   Both requesting: RR_EN=1 grants the requester not served last; RR_EN=0 grants m0.
//   rr pointer updates only when a winner is latched.
//   Aligned legal access -> REQ; misaligned (half addr[0]=1, word addr[1:0]!=0) or size 11 -> ERR.
//  REQ: data_req_o=1 with registered attributes; first bus request appears 1 cycle after the IDLE sample.
//   On data_gnt_i: winner's mN_gnt_o pulses in the same cycle; data_req_o drops next cycle.
//  RESP: data_req_o=0. On data_rvalid_i: winner's mN_rvalid_o pulses in the same cycle,
//   with mN_err_o=data_err_i; rdata = (data_rdata_i >> 8*addr[1:0]) masked to size.
//  ERR: one cycle; winner gets gnt, rvalid and err pulses together; rdata 0; no bus activity.
//  Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
//  Store lanes: wdata << 8*a[1:0].
//  One outstanding transaction. After IDLE, one idle cycle before the next arbitration.
//  Ignored events: data_gnt_i outside REQ; data_rvalid_i outside RESP.
//  The loser's request is not granted and waits; the loser sees no pulses.
//  Reset mid-transaction returns to IDLE; any later stray rvalid is ignored.
// STRUCTURE
//  Shared package dmem_pkg: size encodings (SZ_BYTE/HALF/WORD), state enum (IDLE/REQ/RESP/ERR).
//  Sub-module dmem_lsu_align (combinational): size+addr -> be, misaligned flag, wdata shift,
//   rdata extract.
//  Top holds the FSM, rr pointer, latched transaction and the output mux.
// TESTING
//  1 m0 word load @0x100, gnt 2 cycles later, rvalid 0xDEADBEEF ->
//    req 1 cycle after sample; m0_gnt on gnt; m0_rdata=0xDEADBEEF.
//  2 m0 byte store 0xA5 @0x203 -> be=1000, addr=0x200, wdata=0xA5000000, we=1;
//    half load @0x202, rdata 0x12345678 -> 0x00001234.
//  3 m0,m1 held high 4 transactions, RR_EN=1 -> grant order m0,m1,m0,m1;
//    RR_EN=0 -> all m0 while m0 requests.
//  4 m1 word load @0x101 -> no data_req_o; m1 gnt+rvalid+err same cycle, rdata 0;
//    size 11 behaves the same.
//  5 rvalid with data_err_i=1 -> m0_err_o=1 with m0_rvalid_o;
//    spurious gnt/rvalid in IDLE -> no master pulses.
//  6 rst_ni low in RESP -> all outputs 0 at once; stray rvalid after reset ignored;
//    next request served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory request arbiter: access sizes, arbiter
// states and the byte-lane shift helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } dmem_state_e;

  // Bit distance between byte lane 0 and the lane selected by addr[1:0].
  function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo);
    return {addr_lo, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: byte enables, misalignment detection, store-data
// lane shift and load-data extraction for one access.
module dmem_lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic        misaligned_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_sh;

  always_comb begin
    be_o         = '0;
    misaligned_o = 1'b0;
    rdata_o      = '0;
    rdata_sh     = rdata_i >> lane_shift(addr_lo_i);
    case (dmem_size_e'(size_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        rdata_o = {24'h0, rdata_sh[7:0]};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << addr_lo_i;
        misaligned_o = addr_lo_i[0];
        rdata_o      = {16'h0, rdata_sh[15:0]};
      end
      SZ_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
        rdata_o      = rdata_sh;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

  assign wdata_o = wdata_i << lane_shift(addr_lo_i);

endmodule

// File: rtl/dmem_req_arbiter.sv
// Two-master arbiter for the single data-memory port: picks a winner, runs one
// aligned bus transaction at a time and routes the response back to it.
module dmem_req_arbiter
  import dmem_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_size_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_size_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  dmem_state_e state_q, state_d;
  logic        win_q, win_d;    // 0: m0 owns the transaction, 1: m1
  logic        prio_q, prio_d;  // 1: m1 wins a tie under round-robin
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        pick_m1;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic        al_misaligned;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  logic        gnt_w;
  logic        rvalid_w;
  logic        err_w;
  logic [31:0] rdata_w;

  assign pick_m1   = m1_req_i & (~m0_req_i | (RR_EN & prio_q));
  assign sel_we    = pick_m1 ? m1_we_i    : m0_we_i;
  assign sel_size  = pick_m1 ? m1_size_i  : m0_size_i;
  assign sel_addr  = pick_m1 ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = pick_m1 ? m1_wdata_i : m0_wdata_i;

  // One lane unit serves both phases: in IDLE it screens the candidate for
  // misalignment, afterwards it works on the latched transaction.
  assign al_size    = (state_q == IDLE) ? sel_size      : size_q;
  assign al_addr_lo = (state_q == IDLE) ? sel_addr[1:0] : addr_q[1:0];

  dmem_lsu_align u_align (
    .size_i       (al_size),
    .addr_lo_i    (al_addr_lo),
    .wdata_i      (wdata_q),
    .rdata_i      (data_rdata_i),
    .be_o         (al_be),
    .misaligned_o (al_misaligned),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    prio_d       = prio_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    gnt_w        = 1'b0;
    rvalid_w     = 1'b0;
    err_w        = 1'b0;
    rdata_w      = '0;
    case (state_q)
      IDLE: begin
        if (m0_req_i | m1_req_i) begin
          win_d   = pick_m1;
          prio_d  = ~pick_m1;
          we_d    = sel_we;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = al_misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_be_o    = al_be;
        data_addr_o  = {addr_q[31:2], 2'b00};
        data_wdata_o = al_wdata;
        if (data_gnt_i) begin
          gnt_w   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          rvalid_w = 1'b1;
          err_w    = data_err_i;
          rdata_w  = al_rdata;
          state_d  = IDLE;
        end
      end
      ERR: begin
        gnt_w    = 1'b1;
        rvalid_w = 1'b1;
        err_w    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt_o    = gnt_w & ~win_q;
  assign m0_rvalid_o = rvalid_w & ~win_q;
  assign m0_err_o    = err_w & ~win_q;
  assign m0_rdata_o  = win_q ? '0 : rdata_w;
  assign m1_gnt_o    = gnt_w & win_q;
  assign m1_rvalid_o = rvalid_w & win_q;
  assign m1_err_o    = err_w & win_q;
  assign m1_rdata_o  = win_q ? rdata_w : '0;

endmodule
